// File: rtl/iq_skew_meter_pkg.sv
// Shared state encoding and magnitude helper for the I/Q skew meter.
package iq_skew_meter_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_ARMED = 2'd1;
   localparam state_t ST_DONE  = 2'd2;
   localparam state_t ST_TOOUT = 2'd3;

   // |x| of a w-bit two's-complement value (sign-extended into x); the most
   // negative code saturates to the largest positive code instead of wrapping.
   function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                           input int unsigned         w);
      logic [31:0]        max_v;
      logic signed [31:0] min_v;
      max_v = (32'd1 << (w - 32'd1)) - 32'd1;
      min_v = -$signed(max_v) - 32'sd1;
      if (x == min_v) return max_v;
      if (x < 32'sd0) return 32'(-x);
      return 32'(x);
   endfunction

endpackage

// File: rtl/skew_edge_latch.sv
// First-crossing detector for one rail: latches the beat index of the first
// sample whose saturated magnitude reaches the threshold.
module skew_edge_latch
   import iq_skew_meter_pkg::*;
#(
   parameter int unsigned SAMP_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  beat,
   input  logic                  clear,
   input  logic [SAMP_WIDTH-1:0] sample,
   input  logic [SAMP_WIDTH-1:0] threshold,
   input  logic [CNT_WIDTH-1:0]  counter,
   output logic                  found,
   output logic [CNT_WIDTH-1:0]  index,
   output logic                  hit_c
);

   logic [31:0] mag_c;

   // Magnitude of the current sample and crossing qualifier (first one only).
   assign mag_c = sat_abs(32'($signed(sample)), SAMP_WIDTH);
   assign hit_c = beat && !found && (mag_c >= 32'(threshold));

   // Found flag and index latch; clear wins over a coincident crossing.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         found <= 1'b0;
         index <= '0;
      end else if (clear) begin
         found <= 1'b0;
         index <= '0;
      end else if (hit_c) begin
         found <= 1'b1;
         index <= counter;
      end
   end

endmodule

// File: rtl/iq_skew_meter.sv
// Passive tap on an sc16 {I,Q} stream measuring the beat skew between the
// first threshold crossings on the I and Q rails.
module iq_skew_meter
   import iq_skew_meter_pkg::*;
#(
   parameter int unsigned SAMP_WIDTH = 16,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic [31:0]                 i_tdata,
   input  logic                        i_tlast,
   input  logic                        i_tvalid,
   output logic                        i_tready,
   output logic [31:0]                 o_tdata,
   output logic                        o_tlast,
   output logic                        o_tvalid,
   input  logic                        o_tready,
   input  logic                        arm,
   input  logic [SAMP_WIDTH-1:0]       threshold,
   output logic                        busy,
   output logic                        done,
   output logic                        timeout,
   output logic [CNT_WIDTH-1:0]        i_index,
   output logic [CNT_WIDTH-1:0]        q_index,
   output logic signed [CNT_WIDTH:0]   skew
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
   logic signed [CNT_WIDTH:0] skew_d;
   logic                   beat_c, meas_beat_c;
   logic                   i_found, q_found, i_hit_c, q_hit_c, both_c;
   logic [CNT_WIDTH-1:0]   i_nx_c, q_nx_c;

   // Zero-latency pass-through; the tap never applies backpressure.
   assign o_tdata  = i_tdata;
   assign o_tlast  = i_tlast;
   assign o_tvalid = i_tvalid;
   assign i_tready = o_tready;

   // Only handshakes while armed count; a beat on the arm cycle is dropped.
   assign beat_c      = i_tvalid & o_tready;
   assign meas_beat_c = beat_c & (state_q == ST_ARMED) & ~arm;

   // Per-rail first-crossing latches.
   skew_edge_latch #(.SAMP_WIDTH(SAMP_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_i_latch (
      .clk(clk), .reset_n(reset_n), .beat(meas_beat_c), .clear(arm),
      .sample(i_tdata[31:16]), .threshold(threshold), .counter(cnt_q),
      .found(i_found), .index(i_index), .hit_c(i_hit_c)
   );

   skew_edge_latch #(.SAMP_WIDTH(SAMP_WIDTH), .CNT_WIDTH(CNT_WIDTH)) u_q_latch (
      .clk(clk), .reset_n(reset_n), .beat(meas_beat_c), .clear(arm),
      .sample(i_tdata[15:0]), .threshold(threshold), .counter(cnt_q),
      .found(q_found), .index(q_index), .hit_c(q_hit_c)
   );

   // Index values as they will be after this edge, used to form skew early.
   assign i_nx_c = i_found ? i_index : cnt_q;
   assign q_nx_c = q_found ? q_index : cnt_q;
   assign both_c = (i_found | i_hit_c) & (q_found | q_hit_c);

   // Next-state, counter and skew logic; arm overrides every state.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      skew_d  = skew;
      case (state_q)
         ST_ARMED: begin
            if (meas_beat_c) begin
               cnt_d = cnt_q + 1'b1;
               if (both_c) begin
                  state_d = ST_DONE;
                  skew_d  = $signed({1'b0, q_nx_c}) - $signed({1'b0, i_nx_c});
               end else if (cnt_q == CNT_MAX) begin
                  state_d = ST_TOOUT;
               end
            end
         end
         default: ;
      endcase
      if (arm) begin
         state_d = ST_ARMED;
         cnt_d   = '0;
         skew_d  = '0;
      end
   end

   // State register and registered status outputs.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         skew    <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         skew    <= skew_d;
         busy    <= (state_d == ST_ARMED);
         done    <= (state_d == ST_DONE);
         timeout <= (state_d == ST_TOOUT);
      end
   end

endmodule

// File: tb/tb_iq_skew_meter.sv
// Directed bench for iq_skew_meter: a 16-bit-counter and a 4-bit-counter
// instance share the same stimulus.
module tb_iq_skew_meter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] i_tdata;
   logic        i_tlast, i_tvalid, o_tready, arm;
   logic [15:0] threshold;

   logic        i_tready16, o_tlast16, o_tvalid16, busy16, done16, timeout16;
   logic [31:0] o_tdata16;
   logic [15:0] i_index16, q_index16;
   logic signed [16:0] skew16;

   logic        i_tready4, o_tlast4, o_tvalid4, busy4, done4, timeout4;
   logic [31:0] o_tdata4;
   logic [3:0]  i_index4, q_index4;
   logic signed [4:0] skew4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   iq_skew_meter dut16 (
      .clk(clk), .reset_n(reset_n), .i_tdata(i_tdata), .i_tlast(i_tlast),
      .i_tvalid(i_tvalid), .i_tready(i_tready16), .o_tdata(o_tdata16),
      .o_tlast(o_tlast16), .o_tvalid(o_tvalid16), .o_tready(o_tready),
      .arm(arm), .threshold(threshold), .busy(busy16), .done(done16),
      .timeout(timeout16), .i_index(i_index16), .q_index(q_index16), .skew(skew16)
   );

   iq_skew_meter #(.SAMP_WIDTH(16), .CNT_WIDTH(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .i_tdata(i_tdata), .i_tlast(i_tlast),
      .i_tvalid(i_tvalid), .i_tready(i_tready4), .o_tdata(o_tdata4),
      .o_tlast(o_tlast4), .o_tvalid(o_tvalid4), .o_tready(o_tready),
      .arm(arm), .threshold(threshold), .busy(busy4), .done(done4),
      .timeout(timeout4), .i_index(i_index4), .q_index(q_index4), .skew(skew4)
   );

   typedef struct {
      int thr;
      int ib;   // first I beat at or after which I carries iv
      int iv;
      int qb;   // -1: Q never crosses
      int qv;
      int end_b;
      bit exp_done;
      int exp_i;
      int exp_q;
      int exp_skew;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply one cycle of stimulus, then sample 1 ns after the edge.
   task automatic step(input int iv, input int qv, input logic v, input logic a,
                       input logic r);
      i_tdata  = {16'(iv), 16'(qv)};
      i_tvalid = v;
      arm      = a;
      o_tready = r;
      @(posedge clk);
      #1;
      arm = 1'b0;
   endtask

   task automatic run_vec(input int n, input vec_t t);
      threshold = 16'(t.thr);
      // Arm cycle carries a crossing beat on both rails that must be ignored.
      step(32767, 32767, 1'b1, 1'b1, 1'b1);
      chk($sformatf("v%0d armed busy", n), int'(busy4), 1);
      for (int b = 0; b <= t.end_b; b++) begin
         if (b == t.end_b)
            chk($sformatf("v%0d not early", n), int'(done4 | timeout4), 0);
         step((b >= t.ib) ? t.iv : 0, (t.qb >= 0 && b >= t.qb) ? t.qv : 0,
              1'b1, 1'b0, 1'b1);
      end
      chk($sformatf("v%0d done", n), int'(done4), int'(t.exp_done));
      chk($sformatf("v%0d timeout", n), int'(timeout4), int'(!t.exp_done));
      chk($sformatf("v%0d busy", n), int'(busy4), 0);
      chk($sformatf("v%0d i_index", n), int'(i_index4), t.exp_i);
      chk($sformatf("v%0d q_index", n), int'(q_index4), t.exp_q);
      chk($sformatf("v%0d skew", n), int'(skew4), t.exp_skew);
      if (t.exp_done) begin
         chk($sformatf("v%0d done16", n), int'(done16), 1);
         chk($sformatf("v%0d skew16", n), int'(skew16), t.exp_skew);
      end else begin
         chk($sformatf("v%0d busy16", n), int'(busy16), 1);
      end
      // Results hold while idle.
      step(0, 0, 1'b0, 1'b0, 1'b1);
      chk($sformatf("v%0d hold", n), int'(done4), int'(t.exp_done));
   endtask

   initial begin
      int bc;
      logic v, r, l;

      vecs[0] = '{thr:1000,  ib:5, iv:1200,   qb:12, qv:-1500,  end_b:12, exp_done:1, exp_i:5, exp_q:12, exp_skew:7};
      vecs[1] = '{thr:2000,  ib:3, iv:2000,   qb:3,  qv:-32768, end_b:3,  exp_done:1, exp_i:3, exp_q:3,  exp_skew:0};
      vecs[2] = '{thr:1000,  ib:2, iv:3000,   qb:-1, qv:0,      end_b:15, exp_done:0, exp_i:2, exp_q:0,  exp_skew:0};
      vecs[3] = '{thr:0,     ib:0, iv:0,      qb:0,  qv:0,      end_b:0,  exp_done:1, exp_i:0, exp_q:0,  exp_skew:0};
      vecs[4] = '{thr:100,   ib:9, iv:-101,   qb:1,  qv:100,    end_b:9,  exp_done:1, exp_i:9, exp_q:1,  exp_skew:-8};
      vecs[5] = '{thr:32767, ib:0, iv:-32768, qb:14, qv:32767,  end_b:14, exp_done:1, exp_i:0, exp_q:14, exp_skew:14};

      reset_n = 1'b0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
      o_tready = 1'b1; arm = 1'b0; threshold = '0;
      step(0, 0, 1'b0, 1'b0, 1'b1);
      step(0, 0, 1'b0, 1'b0, 1'b1);
      chk("reset status", int'({busy16, done16, timeout16, busy4, done4, timeout4}), 0);
      chk("reset results", int'(i_index16) + int'(q_index16) + int'(skew16 != 0), 0);
      reset_n = 1'b1;
      step(0, 0, 1'b0, 1'b0, 1'b1);
      chk("idle busy", int'(busy16), 0);

      for (int n = 0; n < 6; n++) run_vec(n, vecs[n]);

      // Random valid/ready: pass-through every cycle, counting only handshakes.
      threshold = 16'd1000;
      step(0, 0, 1'b0, 1'b1, 1'b1);
      bc = 0;
      for (int c = 0; c < 300; c++) begin
         v = 1'($urandom_range(0, 1));
         r = 1'($urandom_range(0, 1));
         l = 1'($urandom_range(0, 1));
         i_tdata  = {16'((bc >= 4) ? 2000 : 0), 16'((bc >= 1) ? -2000 : 0)};
         i_tvalid = v; o_tready = r; i_tlast = l;
         #1;
         chk("pass-through", int'({o_tdata16 == i_tdata, o_tdata4 == i_tdata,
                                   o_tvalid16, o_tvalid4, o_tlast16, o_tlast4,
                                   i_tready16, i_tready4}),
             int'({1'b1, 1'b1, v, v, l, l, r, r}));
         @(posedge clk);
         #1;
         if (v && r) bc++;
         if (done4) break;
      end
      i_tlast = 1'b0;
      chk("bp done", int'(done4), 1);
      chk("bp beats", bc, 5);
      chk("bp i_index", int'(i_index16), 4);
      chk("bp q_index", int'(q_index16), 1);
      chk("bp skew", int'(skew16), -3);

      // Re-arm mid-measurement with I already found.
      threshold = 16'd1000;
      step(0, 0, 1'b0, 1'b1, 1'b1);
      for (int b = 0; b < 6; b++) step((b >= 4) ? 2000 : 0, 0, 1'b1, 1'b0, 1'b1);
      chk("rearm pre i_index", int'(i_index4), 4);
      step(30000, 30000, 1'b1, 1'b1, 1'b1);
      chk("rearm cleared", int'({busy4, done4}) * 100 + int'(i_index4), 200);
      for (int b = 0; b <= 9; b++)
         step((b >= 2) ? 2000 : 0, (b >= 9) ? -2000 : 0, 1'b1, 1'b0, 1'b1);
      chk("rearm done", int'(done4), 1);
      chk("rearm i_index", int'(i_index4), 2);
      chk("rearm q_index", int'(q_index4), 9);
      chk("rearm skew", int'(skew4), 7);

      // Reset mid-measurement, then a clean measurement.
      step(0, 0, 1'b0, 1'b1, 1'b1);
      for (int b = 0; b < 3; b++) step((b >= 1) ? 2000 : 0, 0, 1'b1, 1'b0, 1'b1);
      reset_n = 1'b0;
      i_tdata = 32'h1234_5678; i_tvalid = 1'b1;
      #1;
      chk("reset passthru", int'(o_tdata16 == 32'h1234_5678), 1);
      @(posedge clk);
      #1;
      chk("midreset status", int'({busy4, done4, timeout4, busy16}), 0);
      chk("midreset i_index", int'(i_index4) + int'(i_index16), 0);
      reset_n = 1'b1;
      step(0, 0, 1'b0, 1'b1, 1'b1);
      for (int b = 0; b <= 3; b++)
         step((b >= 3) ? 2000 : 0, (b >= 2) ? 2000 : 0, 1'b1, 1'b0, 1'b1);
      chk("post-reset done", int'(done16), 1);
      chk("post-reset skew", int'(skew16), -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
